// File: rtl/cov_pkg.sv
// Shared types and sizing helpers for the coverage counter bank.
package cov_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_e;

    localparam int N_SIGNALS_DEF = 256;
    localparam int IDX_W         = $clog2(N_SIGNALS_DEF);
    localparam int TOT_W         = IDX_W + 1;

endpackage

// File: rtl/cov_sat_counter.sv
// One saturating hit counter per cover point; flags 0->nonzero and nonzero->0 transitions.
module cov_sat_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic               became_nonzero,
    output logic               became_zero
);

    assign became_nonzero = inc && !clr && (count == '0);
    assign became_zero    = clr && (count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + COUNT_W'(1);
    end

endmodule

// File: rtl/cov_counter_bank.sv
// Per-point saturating hit counters with a running covered count and a valid/ready readout.
module cov_counter_bank
    import cov_pkg::*;
#(
    parameter int N_SIGNALS     = N_SIGNALS_DEF,
    parameter int COUNT_W       = 8,
    parameter bit CLEAR_ON_DUMP = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_SIGNALS-1:0]         cover_in,
    input  logic                         dump_start,
    output logic                         dump_busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(N_SIGNALS)-1:0] out_index,
    output logic [COUNT_W-1:0]           out_count,
    output logic                         out_last,
    output logic [$clog2(N_SIGNALS):0]   covered_total
);

    localparam int IW = $clog2(N_SIGNALS);
    localparam int TW = IW + 1;

    dump_state_e state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [N_SIGNALS-1:0][COUNT_W-1:0] cnt;
    logic [N_SIGNALS-1:0] inc, clr, nz, bz;
    logic [TW-1:0] rise_sum, total_nxt;
    logic at_last, accept;

    assign at_last = (idx == IW'(N_SIGNALS - 1));
    assign accept  = (state == DUMP) && out_ready;

    // Counting is frozen while dumping so the readout is a consistent snapshot.
    for (genvar g = 0; g < N_SIGNALS; g++) begin : g_pt
        assign inc[g] = en && cover_in[g] && (state == IDLE);
        assign clr[g] = CLEAR_ON_DUMP && accept && (idx == IW'(g));

        cov_sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
            .clock          (clock),
            .reset          (reset),
            .inc            (inc[g]),
            .clr            (clr[g]),
            .count          (cnt[g]),
            .became_nonzero (nz[g]),
            .became_zero    (bz[g])
        );
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: if (dump_start) begin
                state_nxt = DUMP;
                idx_nxt   = '0;
            end
            DUMP: if (out_ready) begin
                if (at_last) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // At most one counter clears per cycle, so a single decrement suffices.
    always_comb begin
        rise_sum = '0;
        for (int i = 0; i < N_SIGNALS; i++)
            rise_sum = rise_sum + TW'(nz[i]);
        total_nxt = covered_total + rise_sum - TW'(|bz);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            covered_total <= '0;
        else
            covered_total <= total_nxt;
    end

    assign dump_busy = (state == DUMP);
    assign out_valid = (state == DUMP);
    assign out_index = idx;
    assign out_count = cnt[idx];
    assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_cov_counter_bank.sv
// Randomized bench: driver keeps a count-array model and queues expected beats; monitor checks outputs.
module tb_cov_counter_bank;

    localparam int N    = 16;
    localparam int CW   = 8;
    localparam int IW   = $clog2(N);
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  cover_in;
    logic          dump_start;
    logic          dump_busy;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic [IW:0]   covered_total;

    always #5 clock = ~clock;

    cov_counter_bank #(
        .N_SIGNALS     (N),
        .COUNT_W       (CW),
        .CLEAR_ON_DUMP (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .cover_in      (cover_in),
        .dump_start    (dump_start),
        .dump_busy     (dump_busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .out_count     (out_count),
        .out_last      (out_last),
        .covered_total (covered_total)
    );

    typedef struct {
        int idx;
        int cnt;
        bit last;
    } beat_t;

    beat_t q[$];          // beats still to be accepted in the current dump
    int    model[N];      // hit counts not yet captured by a dump
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_total();
        int t = 0;
        for (int i = 0; i < N; i++) if (model[i] != 0) t++;
        foreach (q[j]) if (q[j].cnt != 0) t++;
        return t;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard head between clock edges.
    always @(negedge clock) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("dump_busy", 32'(dump_busy), 32'(q.size() > 0));
            check("covered_total", 32'(covered_total), 32'(exp_total()));
            if (out_valid && q.size() > 0) begin
                check("out_index", 32'(out_index), 32'(q[0].idx));
                check("out_count", 32'(out_count), 32'(q[0].cnt));
                check("out_last", 32'(out_last), 32'(q[0].last));
            end
        end
    end

    // One clock of stimulus; the model follows the counting/dump rules at the edge.
    task automatic step(input bit e, input logic [N-1:0] c, input bit ds, input bit rdy);
        en = e; cover_in = c; dump_start = ds; out_ready = rdy;
        @(posedge clock);
        if (q.size() > 0) begin
            if (rdy) void'(q.pop_front());
        end else begin
            if (e)
                for (int i = 0; i < N; i++)
                    if (c[i] && model[i] < MAXC) model[i]++;
            if (ds) begin
                for (int i = 0; i < N; i++) begin
                    q.push_back('{idx: i, cnt: model[i], last: (i == N - 1)});
                    model[i] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; cover_in = '0; dump_start = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < N; i++) model[i] = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dump_busy", 32'(dump_busy), 32'd0);
        check("rst_covered_total", 32'(covered_total), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic rand_count(input int cycles);
        for (int k = 0; k < cycles; k++)
            step(($urandom_range(3) != 0), N'($urandom & $urandom), 1'b0, 1'b0);
    endtask

    // mode: 0 ready held high, 1 ready toggling, 2 random ready; storm drives busy inputs mid-dump.
    task automatic run_dump(input int mode, input bit storm, input bit e0, input logic [N-1:0] c0);
        int  guard = 0;
        bit  rdy   = 1'b0;
        step(e0, c0, 1'b1, 1'b1);
        while (q.size() > 0 && guard < 8 * N + 50) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ~rdy;
                default: rdy = 1'($urandom);
            endcase
            if (storm) step(1'b1, '1, guard[0], rdy);
            else       step(1'($urandom), N'($urandom), 1'($urandom), rdy);
            guard++;
        end
        if (q.size() > 0) begin
            check("dump_timeout", 32'(q.size()), 32'd0);
            do_reset();
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cover_in = '0; dump_start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 0;
        #2;
        started = 1'b1;
        do_reset();

        // Single point hit five times.
        for (int k = 0; k < 5; k++) step(1'b1, N'(1 << 3), 1'b0, 1'b0);
        run_dump(0, 1'b0, 1'b0, '0);

        // Three points become covered in one cycle.
        step(1'b1, N'((1 << 1) | (1 << 2) | (1 << 7)), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("total_after_three", 32'(covered_total), 32'd3);
        run_dump(2, 1'b0, 1'b0, '0);

        // Saturation of point 0.
        for (int k = 0; k < 300; k++) step(1'b1, N'(1), 1'b0, 1'b0);
        run_dump(0, 1'b0, 1'b0, '0);

        // Toggling ready.
        rand_count(40);
        run_dump(1, 1'b0, 1'b0, '0);

        // Mid-dump activity must be ignored, then counting resumes from zero.
        rand_count(20);
        run_dump(2, 1'b1, 1'b0, '0);
        rand_count(30);
        run_dump(2, 1'b0, 1'b0, '0);

        // Reset after ten accepted beats.
        rand_count(30);
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 4 * N && q.size() > N - 10; k++) step(1'b0, '0, 1'b0, 1'b1);
        check("beats_before_reset", 32'(q.size()), 32'(N - 10));
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        run_dump(0, 1'b0, 1'b0, '0);

        // Random rounds, including dump_start coinciding with increments.
        for (int r = 0; r < 8; r++) begin
            rand_count($urandom_range(5, 60));
            run_dump($urandom_range(2), 1'b0, 1'b1, N'($urandom));
        end

        step(1'b0, '0, 1'b0, 1'b0);
        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cov_counter_bank.md
Name: cov_counter_bank

Overview:
- Sits directly downstream of the coverage signal tracker. Consumes its flat vector of 1-bit DUT cover points (csr, alu, ctrl, icache, dcache, arb probes).
- Accumulates one saturating hit counter per cover point and maintains a running count of covered points.
- Streams the counters out on a valid/ready interface on request, so the harness can read per-point hit counts at the end of a run.

Parameters:
N_SIGNALS, 256, number of cover inputs (>=2)
COUNT_W, 8, width of each per-point saturating counter (>=2)
CLEAR_ON_DUMP, 1, 1 = zero each counter when its dump beat is accepted

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  count enable; counters increment only when en=1
cover_in  in  N_SIGNALS  cover-point values sampled each cycle (bit i = point i)
dump_start  in  1  single-cycle request to begin a readout
dump_busy  out  1  high while in DUMP state
out_valid  out  1  readout beat valid
out_ready  in  1  consumer accepts beat
out_index  out  $clog2(N_SIGNALS)  cover-point index of current beat
out_count  out  COUNT_W  counter value of point out_index
out_last  out  1  current beat is index N_SIGNALS-1
covered_total  out  $clog2(N_SIGNALS)+1  number of points with counter != 0

Behaviour:
Reset (async, asserted):
- All counters = 0, covered_total = 0, state = IDLE, out_index = 0.
- dump_busy = 0, out_valid = 0, out_last = 0.

States: IDLE, DUMP.

Counting (only in IDLE):
- Each cycle, for every i with en=1 and cover_in[i]=1, counter[i] <= counter[i]+1, unless already all-ones, in which case it holds (saturate, never wraps).
- In DUMP, counting is frozen; cover_in is ignored, so the dump is a consistent snapshot.

covered_total:
- Registered.
- Each cycle it adds the number of counters moving 0 -> 1 and subtracts the number cleared from nonzero -> 0.
- At most one clear per cycle.
- Always equals the popcount of (counter != 0) one cycle after the update.

IDLE -> DUMP:
- On dump_start=1 in IDLE, the next cycle has state DUMP, out_index = 0, out_valid = 1.
- dump_start in DUMP is ignored.
- If en, cover_in and dump_start are all active in the same IDLE cycle, that cycle's increments still take effect.

DUMP:
- out_valid = 1 continuously. out_count = counter[out_index] (combinational mux of registered state). out_last = (out_index == N_SIGNALS-1).
- If out_ready=0, out_index and out_count hold stable.
- On out_valid && out_ready:
  - If CLEAR_ON_DUMP, counter[out_index] <= 0.
  - If not last, out_index increments.
  - If last, the next state is IDLE, out_valid = 0, out_index = 0.
- Throughput is 1 beat/cycle, so a full dump with ready held high takes exactly N_SIGNALS cycles.

dump_busy = (state == DUMP).

Reset mid-dump: returns immediately to IDLE with all counters zeroed. A partial dump is abandoned with no further beats.

Decomposition:
Shared package cov_pkg holds:
- state typedef dump_state_e {IDLE, DUMP}
- localparams derived from N_SIGNALS: IDX_W = $clog2(N_SIGNALS), TOT_W = IDX_W + 1

Sub-module cov_sat_counter (one per cover point, generate loop):
- Inputs: clock, reset, inc, clr.
- Outputs: count[COUNT_W], became_nonzero, became_zero.
- clr has priority over inc.

The top level contains the FSM, the index register, the readout mux and the covered_total adder (a popcount of the became_nonzero pulses).

Test Plan:
1. Reset, then en=1 with cover_in[3]=1 for 5 cycles, then dump with ready=1 -> beat index 3 has count 5, all other beats 0, covered_total=1 before the dump and 0 after (CLEAR_ON_DUMP=1).
2. cover_in[0]=1 for 300 cycles with COUNT_W=8 -> counter[0] saturates at 255 with no wrap; the beat shows 255.
3. Start a dump with out_ready toggling 0/1 every cycle -> beats are in order 0..N-1, no index is skipped or duplicated, out_index/out_count hold while ready=0, out_last only on beat N-1, dump_busy drops the cycle after the last accept.
4. During DUMP, drive cover_in all-ones with en=1 and pulse dump_start again -> counts do not change and no restart occurs; after return to IDLE, counting resumes from 0.
5. Assert reset at beat 10 of a dump -> out_valid=0, dump_busy=0 and covered_total=0 immediately; a new dump returns all zeros.
6. In one cycle, cover_in bits 1, 2 and 7 go high for the first time -> covered_total goes from 0 to 3 the next cycle.
